// File: rtl/input_image_filter_if.sv
// ---------------------------------------------------------------------------
// input_image_filter_if
// Signal bundle between system control / field wiring and the input
// conditioning stage.
//   raw      : asynchronous field inputs (N bits)
//   snap     : scan-start request, single-cycle pulse
//   img      : frozen input image presented to the cores
//   rise     : rising edges accepted since the previous snapshot
//   fall     : falling edges accepted since the previous snapshot
//   snap_ack : one-cycle pulse after each snapshot
//   live     : current debounced level (not frozen)
// Modports:
//   master : the side that supplies raw/snap and consumes the image
//   slave  : the filter itself
// ---------------------------------------------------------------------------
interface input_image_filter_if #(
  parameter int N = 16
);
  logic [N-1:0] raw;
  logic         snap;
  logic [N-1:0] img;
  logic [N-1:0] rise;
  logic [N-1:0] fall;
  logic         snap_ack;
  logic [N-1:0] live;

  modport master (
    output raw, snap,
    input  img, rise, fall, snap_ack, live
  );

  modport slave (
    input  raw, snap,
    output img, rise, fall, snap_ack, live
  );
endinterface

// File: rtl/input_image_filter.sv
// ---------------------------------------------------------------------------
// input_image_filter
// Conditions N raw field inputs for the process-image input of the cores:
// two-flop synchroniser, per-channel debounce against a shared prescaled
// tick, sticky rise/fall accumulation, and a frozen snapshot on scan start.
// Ports:
//   clk : single clock, rising edge
//   rst : asynchronous active-high reset
//   bus : input_image_filter_if.slave (raw, snap in; img, rise, fall,
//         snap_ack, live out). All outputs come straight from flops.
// ---------------------------------------------------------------------------
module input_image_filter #(
  parameter int N       = 16,
  parameter int PRESC   = 1000,
  parameter int PRESC_W = 10,
  parameter int DEB_CNT = 4,
  parameter int DEB_W   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input_image_filter_if.slave   bus
);

  logic [N-1:0]              sy1_reg, sy2_reg;
  logic [PRESC_W-1:0]        pc_reg, pc_next;
  logic                      tick;
  logic [N-1:0]              s_reg, s_next;
  logic [N-1:0][DEB_W-1:0]   c_reg, c_next;
  logic [N-1:0]              rise_ev, fall_ev;
  logic [N-1:0]              racc_reg, facc_reg;
  logic [N-1:0]              img_reg, rise_reg, fall_reg;
  logic                      snap_ack_reg;

  // Free-running prescaler; snapshots never disturb the debounce timebase.
  assign tick    = (pc_reg == PRESC_W'(PRESC - 1));
  assign pc_next = tick ? '0 : pc_reg + PRESC_W'(1);

  // Per-channel debounce. A new level is accepted only after DEB_CNT
  // consecutive disagreeing ticks; any agreeing tick clears the count,
  // which is what rejects glitches shorter than the debounce window.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_chan
      logic             differ;
      logic             commit;
      logic [DEB_W-1:0] c_inc;

      assign differ = sy2_reg[gi] ^ s_reg[gi];
      assign c_inc  = c_reg[gi] + DEB_W'(1);
      assign commit = tick && differ && (c_inc == DEB_W'(DEB_CNT));

      assign s_next[gi]  = commit ? sy2_reg[gi] : s_reg[gi];
      assign c_next[gi]  = !tick              ? c_reg[gi] :
                           (!differ || commit) ? '0        : c_inc;
      assign rise_ev[gi] = commit &  sy2_reg[gi];
      assign fall_ev[gi] = commit & ~sy2_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sy1_reg      <= '0;
      sy2_reg      <= '0;
      pc_reg       <= '0;
      s_reg        <= '0;
      c_reg        <= '0;
      racc_reg     <= '0;
      facc_reg     <= '0;
      img_reg      <= '0;
      rise_reg     <= '0;
      fall_reg     <= '0;
      snap_ack_reg <= 1'b0;
    end else begin
      sy1_reg      <= bus.raw;
      sy2_reg      <= sy1_reg;
      pc_reg       <= pc_next;
      s_reg        <= s_next;
      c_reg        <= c_next;
      snap_ack_reg <= bus.snap;
      if (bus.snap) begin
        // Events committed in the snapshot cycle go straight into the
        // frozen flags and are not left in the accumulators, so they are
        // delivered exactly once.
        img_reg  <= s_next;
        rise_reg <= racc_reg | rise_ev;
        fall_reg <= facc_reg | fall_ev;
        racc_reg <= '0;
        facc_reg <= '0;
      end else begin
        racc_reg <= racc_reg | rise_ev;
        facc_reg <= facc_reg | fall_ev;
      end
    end
  end

  assign bus.img      = img_reg;
  assign bus.rise     = rise_reg;
  assign bus.fall     = fall_reg;
  assign bus.snap_ack = snap_ack_reg;
  assign bus.live     = s_reg;

endmodule

// File: tb/tb_input_image_filter.sv
// ---------------------------------------------------------------------------
// tb_input_image_filter
// Directed bench for input_image_filter with PRESC=4, DEB_CNT=3. Inputs are
// driven 1 time unit after the rising edge and outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_input_image_filter;

  localparam int N = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   pc_model = 0;
  int   cnt;
  int   bad;

  always #5 clk = ~clk;

  input_image_filter_if #(.N(N)) bus ();

  input_image_filter #(
    .N(N), .PRESC(4), .PRESC_W(2), .DEB_CNT(3), .DEB_W(3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference prescaler phase, used only to place stimulus on known ticks.
  always @(posedge clk or posedge rst) begin
    if (rst) pc_model <= 0;
    else     pc_model <= (pc_model == 3) ? 0 : pc_model + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_snap();
    bus.snap = 1'b1;
    step();
    bus.snap = 1'b0;
  endtask

  // Move to the cycle right after a tick edge (prescaler phase 0).
  task automatic align_phase0();
    for (int i = 0; i < 8; i++) begin
      if (pc_model == 0) break;
      step();
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.raw  = 16'hFFFF;
    bus.snap = 1'b0;
    rst      = 1'b1;
    repeat (3) step();

    // Reset holds everything at zero regardless of raw.
    check_eq("rst_img",      32'(bus.img),      32'h0);
    check_eq("rst_rise",     32'(bus.rise),     32'h0);
    check_eq("rst_fall",     32'(bus.fall),     32'h0);
    check_eq("rst_live",     32'(bus.live),     32'h0);
    check_eq("rst_snap_ack", 32'(bus.snap_ack), 32'h0);

    rst = 1'b0;
    step();
    step();
    bus.raw = 16'h0000;
    step();
    step();
    do_snap();                                  // captured on edge 5
    check_eq("first_snap_img", 32'(bus.img),      32'h0);
    check_eq("first_snap_ack", 32'(bus.snap_ack), 32'h1);
    step();
    check_eq("first_ack_drop", 32'(bus.snap_ack), 32'h0);
    repeat (8) step();
    check_eq("idle_live", 32'(bus.live), 32'h0);

    // Clean step on channel 3: commit between 11 and 14 edges after raw.
    bus.raw[3] = 1'b1;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      cnt++;
      if (bus.live[3]) break;
    end
    check_eq("step_lat_min", 32'(cnt >= 11), 32'h1);
    check_eq("step_lat_max", 32'((cnt <= 14) && bus.live[3]), 32'h1);

    // Two back-to-back snapshots: second sees empty edge flags.
    bus.snap = 1'b1;
    step();
    check_eq("step_img",  32'(bus.img),  32'h0008);
    check_eq("step_rise", 32'(bus.rise), 32'h0008);
    check_eq("step_fall", 32'(bus.fall), 32'h0000);
    step();
    bus.snap = 1'b0;
    check_eq("snap2_rise", 32'(bus.rise),     32'h0000);
    check_eq("snap2_img",  32'(bus.img),      32'h0008);
    check_eq("snap2_ack",  32'(bus.snap_ack), 32'h1);
    step();
    check_eq("snap2_ack_drop", 32'(bus.snap_ack), 32'h0);

    // Glitch on channel 5: too short to survive debounce.
    bus.raw[5] = 1'b1;
    repeat (6) step();
    bus.raw[5] = 1'b0;
    bad = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      if (bus.live[5]) bad++;
    end
    check_eq("glitch_live", 32'(bad), 32'h0);
    do_snap();
    check_eq("glitch_rise", 32'(bus.rise), 32'h0000);
    check_eq("glitch_fall", 32'(bus.fall), 32'h0000);

    // Full pulse on channel 0 inside one scan interval.
    bus.raw[0] = 1'b1;
    repeat (40) step();
    bus.raw[0] = 1'b0;
    repeat (20) step();
    do_snap();
    check_eq("pulse_img",  32'(bus.img),  32'h0008);
    check_eq("pulse_rise", 32'(bus.rise), 32'h0001);
    check_eq("pulse_fall", 32'(bus.fall), 32'h0001);

    // Snapshot on the exact edge channel 7 commits (12th edge after raw).
    align_phase0();
    bus.raw[7] = 1'b1;
    repeat (11) step();
    check_eq("coinc_live_pre", 32'(bus.live), 32'h0008);
    do_snap();
    check_eq("coinc_img",  32'(bus.img),  32'h0088);
    check_eq("coinc_rise", 32'(bus.rise), 32'h0080);
    check_eq("coinc_fall", 32'(bus.fall), 32'h0000);
    check_eq("coinc_live", 32'(bus.live), 32'h0088);
    step();
    do_snap();
    check_eq("coinc_next_rise", 32'(bus.rise), 32'h0000);
    check_eq("coinc_next_img",  32'(bus.img),  32'h0088);

    // Reset in the middle of a debounce on channel 9.
    align_phase0();
    bus.raw[9] = 1'b1;
    repeat (8) step();                          // two disagreeing ticks
    check_eq("middeb_live_pre", 32'(bus.live), 32'h0088);
    step();
    rst = 1'b1;
    #1;
    check_eq("middeb_rst_live", 32'(bus.live), 32'h0000);
    check_eq("middeb_rst_img",  32'(bus.img),  32'h0000);
    step();
    rst = 1'b0;
    repeat (11) step();
    check_eq("middeb_restart_pre",  32'(bus.live), 32'h0000);
    step();
    check_eq("middeb_restart_done", 32'(bus.live), 32'h0288);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
